// File: rtl/gb_66_64_pkg.sv
// Shared widths and FSM encoding for the 66b->64b transmit gearbox.
package gb_66_64_pkg;
  localparam int BLK_W  = 66;
  localparam int WORD_W = 64;
  localparam int CNT_W  = 7;
  localparam int ACC_W  = 130;

  localparam logic [CNT_W-1:0] CNT_FULL = 7'd64;
  localparam logic [CNT_W:0]   TOT_BLK  = 8'd66;
  localparam logic [CNT_W:0]   TOT_WORD = 8'd64;

  typedef enum logic {GB_IDLE, GB_RUN} gb_state_t;
endpackage

// File: rtl/gb_66_64_tx_if.sv
// Block-in / word-out bundle between the data mux, the gearbox and the SERDES TX path.
interface gb_66_64_tx_if;
  import gb_66_64_pkg::*;

  logic [WORD_W-1:0] IN_DAT;
  logic [1:0]        IN_SH;
  logic              IN_VAL;
  logic              CLR_ERR;
  logic [WORD_W-1:0] TX_DAT;
  logic              TX_VAL;
  logic              ERR_OVF;
  logic              ERR_UNF;
  logic [CNT_W-1:0]  FILL;

  modport master (
    output IN_DAT, IN_SH, IN_VAL, CLR_ERR,
    input  TX_DAT, TX_VAL, ERR_OVF, ERR_UNF, FILL
  );

  modport slave (
    input  IN_DAT, IN_SH, IN_VAL, CLR_ERR,
    output TX_DAT, TX_VAL, ERR_OVF, ERR_UNF, FILL
  );
endinterface

// File: rtl/gb_bit_insert.sv
// Places a 66b block into the accumulator at bit offset off_i (0..64); combinational.
// Bits at and above the offset are replaced, so stale upper bits never leak into the stream.
module gb_bit_insert
  import gb_66_64_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BLK_W-1:0] blk_i,
  input  logic [CNT_W-1:0] off_i,
  output logic [ACC_W-1:0] acc_o
);
  logic [ACC_W-1:0] keep_mask;
  logic [ACC_W-1:0] blk_shf;

  always_comb begin
    keep_mask = ~({ACC_W{1'b1}} << off_i);
    blk_shf   = {{(ACC_W-BLK_W){1'b0}}, blk_i} << off_i;
    acc_o     = (acc_i & keep_mask) | blk_shf;
  end
endmodule

// File: rtl/gb_66_64_tx.sv
// 66b->64b TX gearbox: one registered 64b word per cycle, block bits out one edge after accept.
// No backpressure; pacing violations raise sticky ERR_OVF/ERR_UNF and optionally resync to IDLE.
module gb_66_64_tx
  import gb_66_64_pkg::*;
#(
  parameter bit RESYNC_ON_ERR = 1'b1
) (
  input logic          CLK219,
  input logic          RST219_N,
  gb_66_64_tx_if.slave bus
);
  gb_state_t         state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ins_acc, comb_acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ins_off;
  logic [CNT_W:0]    tot;
  logic [WORD_W-1:0] tx_dat_q, tx_dat_d;
  logic              tx_val_q, tx_val_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [BLK_W-1:0]  blk;
  logic              run, blk_vld, is_ovf, is_unf;

  assign blk     = {bus.IN_DAT, bus.IN_SH};
  assign blk_vld = bus.IN_VAL;
  assign run     = (state_q == GB_RUN);
  assign is_ovf  = run && blk_vld && (cnt_q == CNT_FULL);
  assign is_unf  = run && !blk_vld && (cnt_q < CNT_FULL);
  // IDLE always restarts the stream at bit 0 of the accumulator
  assign ins_off = run ? cnt_q : '0;
  assign tot     = {1'b0, ins_off} + (blk_vld ? TOT_BLK : '0);

  gb_bit_insert u_ins (
    .acc_i (acc_q),
    .blk_i (blk),
    .off_i (ins_off),
    .acc_o (ins_acc)
  );

  assign comb_acc = blk_vld ? ins_acc : acc_q;

  always_ff @(posedge CLK219) begin
    if (!RST219_N) state_q <= GB_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GB_IDLE: if (blk_vld) state_d = GB_RUN;
      GB_RUN:  if ((is_ovf || is_unf) && RESYNC_ON_ERR) state_d = GB_IDLE;
      default: state_d = GB_IDLE;
    endcase
  end

  always_comb begin
    tx_dat_d = '0;
    tx_val_d = 1'b0;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      GB_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (blk_vld) begin
          tx_dat_d = ins_acc[WORD_W-1:0];
          tx_val_d = 1'b1;
          acc_d    = ins_acc >> WORD_W;
          cnt_d    = CNT_W'(tot - TOT_WORD);
        end
      end
      GB_RUN: begin
        if (is_ovf) begin
          // the 64 held bits go out; the colliding block is dropped
          tx_dat_d = acc_q[WORD_W-1:0];
          tx_val_d = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
        end else if (is_unf) begin
          if (RESYNC_ON_ERR) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end else begin
          tx_dat_d = comb_acc[WORD_W-1:0];
          tx_val_d = 1'b1;
          acc_d    = comb_acc >> WORD_W;
          cnt_d    = CNT_W'(tot - TOT_WORD);
        end
      end
      default: ;
    endcase
  end

  // a new error in the same cycle as CLR_ERR keeps its flag set
  assign ovf_d = is_ovf | (ovf_q & ~bus.CLR_ERR);
  assign unf_d = is_unf | (unf_q & ~bus.CLR_ERR);

  always_ff @(posedge CLK219) begin
    if (!RST219_N) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      tx_dat_q <= '0;
      tx_val_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tx_dat_q <= tx_dat_d;
      tx_val_q <= tx_val_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.TX_DAT  = tx_dat_q;
  assign bus.TX_VAL  = tx_val_q;
  assign bus.ERR_OVF = ovf_q;
  assign bus.ERR_UNF = unf_q;
  assign bus.FILL    = cnt_q;
endmodule

// File: tb/tb_gb_66_64_tx.sv
// Bench for gb_66_64_tx: one DUT per RESYNC_ON_ERR value, both fed the same stimulus and
// checked each cycle against a bit-queue model of the stream, plus directed literal checks.
module tb_gb_66_64_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val;
  logic        clr_err;
  logic [63:0] in_dat;
  logic [1:0]  in_sh;

  gb_66_64_tx_if bus1 ();
  gb_66_64_tx_if bus0 ();

  assign bus1.IN_DAT  = in_dat;
  assign bus1.IN_SH   = in_sh;
  assign bus1.IN_VAL  = in_val;
  assign bus1.CLR_ERR = clr_err;
  assign bus0.IN_DAT  = in_dat;
  assign bus0.IN_SH   = in_sh;
  assign bus0.IN_VAL  = in_val;
  assign bus0.CLR_ERR = clr_err;

  gb_66_64_tx #(.RESYNC_ON_ERR(1'b1)) u_dut1 (.CLK219(clk), .RST219_N(rst_n), .bus(bus1));
  gb_66_64_tx #(.RESYNC_ON_ERR(1'b0)) u_dut0 (.CLK219(clk), .RST219_N(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  localparam logic [63:0] DAT0 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] EXP0 = 64'hFB72_EA61_D950_C842;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          mdl_ok = 1'b0;

  // model: index 1 = resync DUT, index 0 = hold DUT; the stream is a plain bit list
  bit          mbits [2][256];
  int          mlen  [2];
  bit          mrun  [2];
  logic [63:0] ex_dat [2];
  bit          ex_val [2];
  bit          ex_ovf [2];
  bit          ex_unf [2];

  bit          rxb[$];
  logic [65:0] sent_q[$];
  int          nblk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_word(input int m);
    for (int i = 0; i < 64; i++) ex_dat[m][i] = mbits[m][i];
    for (int i = 0; i < mlen[m] - 64; i++) mbits[m][i] = mbits[m][i+64];
    mlen[m] -= 64;
  endtask

  task automatic model_mode(input int m, input bit resync);
    logic [65:0] blk;
    bit ovf, unf;
    blk = {in_dat, in_sh};
    ovf = 1'b0;
    unf = 1'b0;
    ex_dat[m] = '0;
    ex_val[m] = 1'b0;
    if (!rst_n) begin
      mlen[m]   = 0;
      mrun[m]   = 1'b0;
      ex_ovf[m] = 1'b0;
      ex_unf[m] = 1'b0;
    end else begin
      if (mrun[m] && in_val && mlen[m] == 64) begin
        ovf = 1'b1;
        pop_word(m);
        ex_val[m] = 1'b1;
        if (resync) mrun[m] = 1'b0;
      end else if (mrun[m] && !in_val && mlen[m] < 64) begin
        unf = 1'b1;
        if (resync) begin
          mlen[m] = 0;
          mrun[m] = 1'b0;
        end
      end else if (mrun[m] || in_val) begin
        if (in_val) begin
          for (int i = 0; i < 66; i++) mbits[m][mlen[m]+i] = blk[i];
          mlen[m] += 66;
        end
        pop_word(m);
        ex_val[m] = 1'b1;
        mrun[m]   = 1'b1;
      end
      ex_ovf[m] = ovf | (ex_ovf[m] & !clr_err);
      ex_unf[m] = unf | (ex_unf[m] & !clr_err);
    end
  endtask

  always @(posedge clk) begin
    model_mode(1, 1'b1);
    model_mode(0, 1'b0);
    mdl_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("d1.TX_DAT",  bus1.TX_DAT,          ex_dat[1]);
      chk("d1.TX_VAL",  64'(bus1.TX_VAL),     64'(ex_val[1]));
      chk("d1.ERR_OVF", 64'(bus1.ERR_OVF),    64'(ex_ovf[1]));
      chk("d1.ERR_UNF", 64'(bus1.ERR_UNF),    64'(ex_unf[1]));
      chk("d1.FILL",    64'(bus1.FILL),       64'(mlen[1]));
      chk("d0.TX_DAT",  bus0.TX_DAT,          ex_dat[0]);
      chk("d0.TX_VAL",  64'(bus0.TX_VAL),     64'(ex_val[0]));
      chk("d0.ERR_OVF", 64'(bus0.ERR_OVF),    64'(ex_ovf[0]));
      chk("d0.ERR_UNF", 64'(bus0.ERR_UNF),    64'(ex_unf[0]));
      chk("d0.FILL",    64'(bus0.FILL),       64'(mlen[0]));
    end
  end

  task automatic drive(input bit r, input bit v, input logic [63:0] d, input logic [1:0] s,
                       input bit c);
    rst_n   = r;
    in_val  = v;
    in_dat  = d;
    in_sh   = s;
    clr_err = c;
    @(posedge clk);
    #2;
  endtask

  // rebuild 66b blocks from the emitted word stream and match them against what was sent
  task automatic collect();
    logic [65:0] rb;
    logic [65:0] want;
    if (bus1.TX_VAL) begin
      for (int i = 0; i < 64; i++) rxb.push_back(bus1.TX_DAT[i]);
    end
    while (rxb.size() >= 66) begin
      for (int i = 0; i < 66; i++) rb[i] = rxb.pop_front();
      want = (sent_q.size() > 0) ? sent_q.pop_front() : 66'h0;
      nblk++;
      n_cmp++;
      if (rb !== want) begin
        n_err++;
        $display("FAIL reasm.blk%0d: got %h want %h", nblk, rb, want);
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    int          ph;
    bit          v, c, r;

    rst_n = 1'b0; in_val = 1'b0; in_dat = '0; in_sh = '0; clr_err = 1'b0;
    drive(0, 0, '0, 2'b00, 0);
    drive(0, 0, '0, 2'b00, 0);
    chk("rst.TX_DAT",  bus1.TX_DAT,       64'd0);
    chk("rst.TX_VAL",  64'(bus1.TX_VAL),  64'd0);
    chk("rst.ERR_OVF", 64'(bus1.ERR_OVF), 64'd0);
    chk("rst.ERR_UNF", 64'(bus1.ERR_UNF), 64'd0);
    chk("rst.FILL",    64'(bus1.FILL),    64'd0);

    drive(1, 1, DAT0, 2'b10, 0);
    chk("first.TX_DAT", bus1.TX_DAT,      EXP0);
    chk("first.TX_VAL", 64'(bus1.TX_VAL), 64'd1);
    chk("first.FILL",   64'(bus1.FILL),   64'd2);

    // steady pacing: 32 blocks + 1 gap per period
    drive(0, 0, '0, 2'b00, 0);
    rxb.delete();
    sent_q.delete();
    nblk = 0;
    for (int p = 0; p < 10; p++) begin
      for (int k = 1; k <= 32; k++) begin
        d = 64'h1000_0000_0000_0000 + 64'(p * 32 + k);
        sent_q.push_back({d, 2'b01});
        drive(1, 1, d, 2'b01, 0);
        chk("ss.FILL",   64'(bus1.FILL),   64'(2 * k));
        chk("ss.TX_VAL", 64'(bus1.TX_VAL), 64'd1);
        collect();
      end
      drive(1, 0, '0, 2'b00, 0);
      chk("ss.FILL_gap",   64'(bus1.FILL),   64'd0);
      chk("ss.TX_VAL_gap", 64'(bus1.TX_VAL), 64'd1);
      collect();
    end
    chk("reasm.count", 64'(nblk),       64'd320);
    chk("reasm.left",  64'(rxb.size()), 64'd0);
    chk("ss.ERR_OVF",  64'(bus1.ERR_OVF | bus0.ERR_OVF), 64'd0);
    chk("ss.ERR_UNF",  64'(bus1.ERR_UNF | bus0.ERR_UNF), 64'd0);

    // 33 back-to-back blocks: the 33rd collides with a full residual
    drive(0, 0, '0, 2'b00, 0);
    for (int k = 1; k <= 32; k++) drive(1, 1, 64'hA5A5_0000_0000_0000 + 64'(k), 2'b01, 0);
    drive(1, 1, 64'h5A5A_5A5A_5A5A_5A5A, 2'b10, 0);
    chk("ovf.TX_DAT",   bus1.TX_DAT,       64'hA5A5_0000_0000_0020);
    chk("ovf.TX_VAL",   64'(bus1.TX_VAL),  64'd1);
    chk("ovf.ERR_OVF",  64'(bus1.ERR_OVF), 64'd1);
    chk("ovf.FILL",     64'(bus1.FILL),    64'd0);
    chk("ovf0.ERR_OVF", 64'(bus0.ERR_OVF), 64'd1);
    chk("ovf0.FILL",    64'(bus0.FILL),    64'd0);
    d = 64'h0123_4567_89AB_CDEF;
    drive(1, 1, d, 2'b01, 1);
    chk("restart.TX_DAT",  bus1.TX_DAT,       {d[61:0], 2'b01});
    chk("restart.FILL",    64'(bus1.FILL),    64'd2);
    chk("clr.ERR_OVF",     64'(bus1.ERR_OVF), 64'd0);
    chk("clr0.ERR_OVF",    64'(bus0.ERR_OVF), 64'd0);
    chk("restart0.FILL",   64'(bus0.FILL),    64'd2);
    for (int k = 0; k < 31; k++) drive(1, 1, {$urandom, $urandom}, 2'b01, 0);
    chk("full.FILL", 64'(bus1.FILL), 64'd64);
    drive(1, 1, {$urandom, $urandom}, 2'b01, 1);
    chk("setwins.ERR_OVF",  64'(bus1.ERR_OVF), 64'd1);
    chk("setwins0.ERR_OVF", 64'(bus0.ERR_OVF), 64'd1);

    // underflow after 5 blocks
    drive(0, 0, '0, 2'b00, 0);
    for (int k = 0; k < 5; k++) drive(1, 1, {$urandom, $urandom}, 2'b10, 0);
    chk("unf.pre_FILL", 64'(bus1.FILL), 64'd10);
    drive(1, 0, '0, 2'b00, 0);
    chk("unf1.TX_VAL",  64'(bus1.TX_VAL),  64'd0);
    chk("unf1.TX_DAT",  bus1.TX_DAT,       64'd0);
    chk("unf1.ERR_UNF", 64'(bus1.ERR_UNF), 64'd1);
    chk("unf1.FILL",    64'(bus1.FILL),    64'd0);
    chk("unf0.TX_VAL",  64'(bus0.TX_VAL),  64'd0);
    chk("unf0.ERR_UNF", 64'(bus0.ERR_UNF), 64'd1);
    chk("unf0.FILL",    64'(bus0.FILL),    64'd10);
    drive(1, 1, {$urandom, $urandom}, 2'b01, 0);
    chk("unf0.next_FILL", 64'(bus0.FILL), 64'd12);
    chk("unf1.next_FILL", 64'(bus1.FILL), 64'd2);

    // reset mid-stream at FILL=40
    drive(0, 0, '0, 2'b00, 0);
    for (int k = 0; k < 20; k++) drive(1, 1, {$urandom, $urandom}, 2'b01, 0);
    chk("mid.FILL", 64'(bus1.FILL), 64'd40);
    drive(0, 1, {$urandom, $urandom}, 2'b01, 0);
    chk("mid.TX_DAT", bus1.TX_DAT,       64'd0);
    chk("mid.TX_VAL", 64'(bus1.TX_VAL),  64'd0);
    chk("mid.FILL",   64'(bus1.FILL),    64'd0);
    chk("mid.flags",  64'(bus1.ERR_OVF | bus1.ERR_UNF), 64'd0);
    drive(1, 1, DAT0, 2'b10, 0);
    chk("mid.first_TX_DAT", bus1.TX_DAT,    EXP0);
    chk("mid.first_FILL",   64'(bus1.FILL), 64'd2);

    // randomized: mostly paced, with pacing slips, error clears and rare resets
    ph = 0;
    for (int i = 0; i < 3000; i++) begin
      v = (ph != 32);
      if ($urandom_range(0, 63) == 0) v = !v;
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 399) != 0);
      drive(r, v, {$urandom, $urandom}, 2'($urandom_range(0, 3)), c);
      ph = (ph == 32) ? 0 : ph + 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
